conv3x3_engine: RTL and testbench

Parametrised 3x3 multi-channel convolution engine fed from a 4-bank rotating line buffer. Computes CH_OUT output maps as the sum over CH_IN input channels of 3x3 dot products plus bias, with saturation and optional ReLU. Weights and biases are run-time loadable instead of hard-wired. It tracks available input rows with a row-credit counter and frame position, and writes one output row per pass to a ping-pong output buffer for the downstream max-pool or conv stage.

---
 rtl/conv3x3_engine.sv | 230 +++++++++++++++++++++++
 tb/tb_conv3x3_engine.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_engine.sv
// 3x3 multi-channel convolution over a 4-bank rotating line buffer with run-time coefficients.
// Pipeline: BRAM read, window capture, products, sum, bias/saturate/ReLU output register.
module conv3x3_engine #(
    parameter int IN_BD  = 8,
    parameter int W_BD   = 8,
    parameter int ACC_BD = 18,
    parameter int CH_IN  = 3,
    parameter int CH_OUT = 3,
    parameter int IMG_W  = 1920,
    parameter int IMG_H  = 1080,
    parameter int RELU   = 1
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        row_ready,
    input  logic [4*CH_IN*IN_BD-1:0]                    lb_q,
    output logic                                        lb_rd_en,
    output logic [$clog2(IMG_W)-1:0]                    lb_rd_addr,
    input  logic                                        cfg_we,
    input  logic [$clog2(CH_OUT*CH_IN*9+CH_OUT)-1:0]    cfg_addr,
    input  logic [ACC_BD-1:0]                           cfg_data,
    output logic                                        cfg_err,
    output logic                                        out_we,
    output logic [$clog2(IMG_W-2)-1:0]                  out_addr,
    output logic [CH_OUT*ACC_BD-1:0]                    out_data,
    output logic                                        out_bank,
    output logic                                        row_done,
    output logic                                        frame_done,
    output logic                                        busy,
    output logic                                        overflow
);
    localparam int NW  = CH_OUT*CH_IN*9;
    localparam int CAW = $clog2(NW + CH_OUT);
    localparam int AW  = $clog2(IMG_W);
    localparam int OAW = $clog2(IMG_W-2);
    localparam int RW  = $clog2(IMG_H);
    localparam int PW  = IN_BD + W_BD + 1;
    localparam int SW  = PW + $clog2(9*CH_IN);
    localparam int TW  = ((SW > ACC_BD) ? SW : ACC_BD) + 1;
    localparam logic signed [TW-1:0] SMAX = {{(TW-ACC_BD+1){1'b0}}, {(ACC_BD-1){1'b1}}};
    localparam logic signed [TW-1:0] SMIN = {{(TW-ACC_BD+1){1'b1}}, {(ACC_BD-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                    state_q, state_d;
    logic [AW-1:0]             rd_col_q, rd_col_d;
    logic [2:0]                rows_q, rows_d;
    logic [1:0]                base_q, base_d;
    logic [RW-1:0]             orow_q, orow_d;
    logic                      bank_q, bank_d;
    logic                      ovf_q, ovf_d;
    logic                      cerr_q, cerr_d;
    logic                      done, fdone;

    logic signed [W_BD-1:0]    w_q    [NW];
    logic signed [ACC_BD-1:0]  bias_q [CH_OUT];

    logic [IN_BD-1:0]          lb_pix  [4][CH_IN];
    logic [1:0]                bank_r  [3];
    logic [IN_BD-1:0]          win_q   [CH_IN][3][3];
    logic signed [PW-1:0]      prod_q  [CH_OUT][CH_IN][9];
    logic signed [TW-1:0]      sum_d   [CH_OUT];
    logic signed [TW-1:0]      sum_q   [CH_OUT];
    logic signed [TW-1:0]      tot;
    logic [CH_OUT*ACC_BD-1:0]  res_d;

    logic                      v1_q, wv_q, pv_q, sv_q, out_we_q;
    logic [AW-1:0]             c1_q;
    logic [OAW-1:0]            wc_q, pc_q, sc_q, out_addr_q;
    logic [CH_OUT*ACC_BD-1:0]  out_data_q;

    always_comb begin
        state_d  = state_q;
        rd_col_d = '0;
        rows_d   = rows_q;
        base_d   = base_q;
        orow_d   = orow_q;
        bank_d   = bank_q;
        ovf_d    = ovf_q;
        cerr_d   = cfg_we && (state_q != IDLE);
        done     = (state_q == DONE);
        fdone    = done && (orow_q == RW'(IMG_H-3));
        unique case (state_q)
            IDLE:  if (rows_q >= 3'd3) state_d = READ;
            READ: begin
                rd_col_d = rd_col_q + AW'(1);
                if (rd_col_q == AW'(IMG_W-1)) begin
                    rd_col_d = '0;
                    state_d  = DRAIN;
                end
            end
            DRAIN: if (out_we_q && out_addr_q == OAW'(IMG_W-3)) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A frame end releases every held row; a coincident row_ready becomes the first of the next frame.
        if (fdone)                 rows_d = row_ready ? 3'd1 : 3'd0;
        else if (row_ready && done) rows_d = rows_q;
        else if (row_ready) begin
            if (rows_q == 3'd4) ovf_d  = 1'b1;
            else                rows_d = rows_q + 3'd1;
        end else if (done)          rows_d = rows_q - 3'd1;
        if (done) begin
            base_d = base_q + (fdone ? 2'd3 : 2'd1);
            orow_d = fdone ? '0 : orow_q + RW'(1);
            bank_d = ~bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rd_col_q <= '0;
            rows_q   <= '0;
            base_q   <= '0;
            orow_q   <= '0;
            bank_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_col_q <= rd_col_d;
            rows_q   <= rows_d;
            base_q   <= base_d;
            orow_q   <= orow_d;
            bank_q   <= bank_d;
            ovf_q    <= ovf_d;
            cerr_q   <= cerr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned a = 0; a < NW; a++) w_q[a] <= '0;
            for (int unsigned o = 0; o < CH_OUT; o++) bias_q[o] <= '0;
        end else if (cfg_we && state_q == IDLE) begin
            for (int unsigned a = 0; a < NW; a++)
                if (cfg_addr == CAW'(a)) w_q[a] <= cfg_data[W_BD-1:0];
            for (int unsigned o = 0; o < CH_OUT; o++)
                if (cfg_addr == CAW'(NW + o)) bias_q[o] <= cfg_data;
        end
    end

    always_comb begin
        for (int unsigned b = 0; b < 4; b++)
            for (int unsigned i = 0; i < CH_IN; i++)
                lb_pix[b][i] = lb_q[(b*CH_IN+i)*IN_BD +: IN_BD];
        for (int unsigned r = 0; r < 3; r++)
            bank_r[r] = base_q + 2'(r);
    end

    always_ff @(posedge clk) begin
        if (v1_q) begin
            for (int unsigned i = 0; i < CH_IN; i++)
                for (int unsigned r = 0; r < 3; r++) begin
                    win_q[i][r][0] <= win_q[i][r][1];
                    win_q[i][r][1] <= win_q[i][r][2];
                    win_q[i][r][2] <= lb_pix[bank_r[r]][i];
                end
        end
        for (int unsigned o = 0; o < CH_OUT; o++)
            for (int unsigned i = 0; i < CH_IN; i++)
                for (int unsigned k = 0; k < 9; k++)
                    prod_q[o][i][k] <= PW'($signed({1'b0, win_q[i][k/3][k%3]})) * PW'(w_q[(o*CH_IN+i)*9+k]);
        sum_q <= sum_d;
    end

    always_comb begin
        for (int unsigned o = 0; o < CH_OUT; o++) begin
            sum_d[o] = '0;
            for (int unsigned i = 0; i < CH_IN; i++)
                for (int unsigned k = 0; k < 9; k++)
                    sum_d[o] = sum_d[o] + TW'(prod_q[o][i][k]);
        end
    end

    always_comb begin
        res_d = '0;
        tot   = '0;
        for (int unsigned o = 0; o < CH_OUT; o++) begin
            tot = sum_q[o] + TW'(bias_q[o]);
            if (tot > SMAX)      tot = SMAX;
            else if (tot < SMIN) tot = SMIN;
            if (RELU != 0 && tot[TW-1]) tot = '0;
            res_d[o*ACC_BD +: ACC_BD] = tot[ACC_BD-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q       <= 1'b0;
            c1_q       <= '0;
            wv_q       <= 1'b0;
            wc_q       <= '0;
            pv_q       <= 1'b0;
            pc_q       <= '0;
            sv_q       <= 1'b0;
            sc_q       <= '0;
            out_we_q   <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
        end else begin
            v1_q       <= lb_rd_en;
            c1_q       <= lb_rd_addr;
            // A window is complete once its third column has been shifted in.
            wv_q       <= v1_q && (c1_q >= AW'(2));
            wc_q       <= OAW'(c1_q - AW'(2));
            pv_q       <= wv_q;
            pc_q       <= wc_q;
            sv_q       <= pv_q;
            sc_q       <= pc_q;
            out_we_q   <= sv_q;
            out_addr_q <= sc_q;
            if (sv_q) out_data_q <= res_d;
        end
    end

    assign lb_rd_en   = (state_q == READ);
    assign lb_rd_addr = rd_col_q;
    assign cfg_err    = cerr_q;
    assign out_we     = out_we_q;
    assign out_addr   = out_addr_q;
    assign out_data   = out_data_q;
    assign out_bank   = bank_q;
    assign row_done   = done;
    assign frame_done = fdone;
    assign busy       = (state_q != IDLE);
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed bench for conv3x3_engine (IMG_W=8, IMG_H=4); a RELU=0 twin shares all inputs.
module tb_conv3x3_engine;
    localparam int IN_BD = 8, W_BD = 8, ACC_BD = 18, CH_IN = 3, CH_OUT = 3;
    localparam int IMG_W = 8, IMG_H = 4;
    localparam int NW = CH_OUT*CH_IN*9;

    logic                          clk = 1'b0;
    logic                          reset, row_ready, cfg_we;
    logic [6:0]                    cfg_addr;
    logic [ACC_BD-1:0]             cfg_data;
    logic [4*CH_IN*IN_BD-1:0]      lb_q = '0;
    logic                          lb_rd_en, cfg_err, out_we, out_bank, row_done, frame_done, busy, overflow;
    logic [2:0]                    lb_rd_addr, out_addr;
    logic [CH_OUT*ACC_BD-1:0]      out_data;
    logic                          lb_rd_en2, cfg_err2, out_we2, out_bank2, row_done2, frame_done2, busy2, overflow2;
    logic [2:0]                    lb_rd_addr2, out_addr2;
    logic [CH_OUT*ACC_BD-1:0]      out_data2;

    logic [IN_BD-1:0]              pix [4][IMG_W][CH_IN];
    int                            checks = 0, errors = 0;
    logic                          exp_bank = 1'b0;

    conv3x3_engine #(.IMG_W(IMG_W), .IMG_H(IMG_H), .RELU(1)) dut (
        .clk(clk), .reset(reset), .row_ready(row_ready), .lb_q(lb_q),
        .lb_rd_en(lb_rd_en), .lb_rd_addr(lb_rd_addr),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data), .out_bank(out_bank),
        .row_done(row_done), .frame_done(frame_done), .busy(busy), .overflow(overflow));

    conv3x3_engine #(.IMG_W(IMG_W), .IMG_H(IMG_H), .RELU(0)) dut2 (
        .clk(clk), .reset(reset), .row_ready(row_ready), .lb_q(lb_q),
        .lb_rd_en(lb_rd_en2), .lb_rd_addr(lb_rd_addr2),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err2),
        .out_we(out_we2), .out_addr(out_addr2), .out_data(out_data2), .out_bank(out_bank2),
        .row_done(row_done2), .frame_done(frame_done2), .busy(busy2), .overflow(overflow2));

    always #5 clk = ~clk;

    function automatic logic [4*CH_IN*IN_BD-1:0] rd_word(input logic [2:0] a);
        rd_word = '0;
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < CH_IN; i++)
                rd_word[(b*CH_IN+i)*IN_BD +: IN_BD] = pix[b][a][i];
    endfunction

    always @(posedge clk) if (lb_rd_en) lb_q <= rd_word(lb_rd_addr);

    function automatic logic [CH_OUT*ACC_BD-1:0] pack(input int v);
        logic [ACC_BD-1:0] s;
        s = ACC_BD'(v);
        pack = '0;
        for (int o = 0; o < CH_OUT; o++) pack[o*ACC_BD +: ACC_BD] = s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_out_we"},   out_we, 0);
        chk({tag, "_out_addr"}, out_addr, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_bank"}, out_bank, 0);
        chk({tag, "_row_done"}, {row_done, frame_done}, 0);
        chk({tag, "_busy"},     busy, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_lb_rd"},    {lb_rd_en, lb_rd_addr}, 0);
        chk({tag, "_cfg_err"},  cfg_err, 0);
        chk({tag, "_twin"}, {lb_rd_en2, lb_rd_addr2, cfg_err2, out_we2, out_addr2, out_data2,
                             out_bank2, row_done2, frame_done2, busy2, overflow2}, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; row_ready = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        reset = 1'b0;
        exp_bank = 1'b0;
    endtask

    task automatic wr_cfg(input int a, input int d);
        cfg_we = 1'b1; cfg_addr = 7'(a); cfg_data = ACC_BD'(d);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // mode 0: every weight; 1: centre tap only; 2: channel 0 top-middle tap only
    task automatic load(input int mode, input int val, input int bias);
        int w;
        for (int o = 0; o < CH_OUT; o++)
            for (int i = 0; i < CH_IN; i++)
                for (int k = 0; k < 9; k++) begin
                    w = (mode == 0) ? val : (mode == 1 && k == 4) ? val : (mode == 2 && i == 0 && k == 1) ? val : 0;
                    wr_cfg((o*CH_IN+i)*9+k, w);
                end
        for (int o = 0; o < CH_OUT; o++) wr_cfg(NW+o, bias);
    endtask

    // mode 0: constant v; 1: pixel = column; 2: pixel = 10*(bank+1)
    task automatic fill(input int mode, input int v);
        for (int b = 0; b < 4; b++)
            for (int x = 0; x < IMG_W; x++)
                for (int i = 0; i < CH_IN; i++)
                    pix[b][x][i] = IN_BD'((mode == 0) ? v : (mode == 1) ? x : 10*(b+1));
    endtask

    task automatic pulse(input int n);
        for (int p = 0; p < n; p++) begin
            row_ready = 1'b1;
            @(negedge clk);
            row_ready = 1'b0;
        end
    endtask

    task automatic run_row(input string tag, input int base, input int slope, input int base2,
                           input bit fd, input int rdy_k, input bit probe, input bit ovf_exp);
        int n;
        int j;
        n = 0;
        while (!(lb_rd_en === 1'b1 && lb_rd_addr === 3'd0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_t0_timeout"}, (n < 200), 1);
        chk({tag, "_busy_t0"}, busy, 1);
        for (int k = 1; k <= IMG_W+6; k++) begin
            @(negedge clk);
            row_ready = (k == rdy_k);
            cfg_we = probe && (k == 2);
            if (cfg_we) begin cfg_addr = 7'(NW); cfg_data = 18'd5; end
            if (k >= 7 && k <= IMG_W+4) begin
                j = k - 7;
                chk({tag, "_out_we"},    out_we, 1);
                chk({tag, "_out_addr"},  out_addr, j);
                chk({tag, "_out_data"},  out_data, pack(base + slope*j));
                chk({tag, "_out_data2"}, out_data2, pack(base2 + slope*j));
            end else begin
                chk({tag, "_out_we_idle"}, out_we, 0);
            end
            chk({tag, "_row_done"},   row_done, (k == IMG_W+5));
            chk({tag, "_frame_done"}, frame_done, (k == IMG_W+5) && fd);
            if (probe && k == 3) chk({tag, "_cfg_err"}, cfg_err, 1);
            if (k == IMG_W+5) exp_bank = ~exp_bank;
            if (k == IMG_W+6) begin
                chk({tag, "_out_bank"}, out_bank, exp_bank);
                chk({tag, "_busy_end"}, busy, 0);
            end
        end
        chk({tag, "_overflow"}, overflow, ovf_exp);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        do_reset();

        fill(0, 10);
        load(0, 1, 0);
        pulse(3);
        run_row("t1", 270, 0, 270, 0, -1, 0, 0);
        @(negedge clk);
        chk("t1_two_rows_idle", lb_rd_en, 0);

        pulse(1);
        run_row("t2_busy_cfg", 270, 0, 270, 1, -1, 1, 0);
        pulse(3);
        run_row("t2_after", 270, 0, 270, 0, -1, 0, 0);

        do_reset();
        fill(1, 0);
        load(1, 1, 0);
        pulse(3);
        run_row("t3_ramp", 3, 3, 3, 0, -1, 0, 0);

        do_reset();
        fill(0, 255);
        load(0, -127, 0);
        pulse(3);
        run_row("t4_neg", 0, 0, -131072, 0, -1, 0, 0);
        load(0, 127, 131071);
        pulse(1);
        run_row("t4_pos", 131071, 0, 131071, 1, -1, 0, 0);

        do_reset();
        fill(2, 0);
        load(2, 1, 0);
        pulse(3);
        run_row("t5_base0", 10, 0, 10, 0, IMG_W+5, 0, 0);
        @(negedge clk);
        chk("t5_same_cycle_credit", {lb_rd_en, lb_rd_addr}, 4'b1000);
        run_row("t5_base1", 20, 0, 20, 1, -1, 0, 0);
        pulse(4);
        run_row("t5_wrap", 10, 0, 10, 0, 1, 0, 1);

        @(negedge clk);
        chk("t6_t0", {lb_rd_en, lb_rd_addr}, 4'b1000);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_idle("t6_midrow");
        reset = 1'b0;
        exp_bank = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("t6_quiet", {out_we, lb_rd_en}, 0);
        end
        fill(0, 10);
        load(0, 1, 0);
        pulse(3);
        run_row("t6_recover", 270, 0, 270, 0, -1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
